// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch and memory stages.
// Each grant runs one wait-state handshake and ends with a one-cycle done pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACC_D, ACC_F, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_data_q, last_data_d;  // 1: data stage won the last grant
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic                err_q, err_d;
  logic                fin;
  logic [DATA_W-1:0]   fin_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = err_q;
    fin         = 1'b0;
    fin_data    = mem_rdata;

    unique case (state_q)
      IDLE: begin
        // On a tie the stage that did not win last time gets the grant.
        if (dm_req && (!if_req || !last_data_q)) begin
          state_d     = ACC_D;
          cnt_d       = '0;
          last_data_d = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d     = ACC_F;
          cnt_d       = '0;
          last_data_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
        end
      end
      ACC_D, ACC_F: begin
        // Ready takes priority over the timeout threshold in the same cycle.
        if (mem_ready) begin
          fin = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          fin      = 1'b1;
          fin_data = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d   = DONE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == ACC_D) begin
        dm_done_d  = 1'b1;
        dm_rdata_d = fin_data;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized accesses checked
// against a transaction-level model (grant rule, done cycle, returned data).
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, dm_done, mem_req, mem_we, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit            last_data;
  bit            err_m;
  logic [DW-1:0] wdata_m;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    tick; tick;
    reset = 1'b1;
    last_data = 0; err_m = 0; wdata_m = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 1; dm_req = 1; dm_we = 1; mem_ready = 1;
    dm_addr = 32'h1234; dm_wdata = 32'hdead; mem_rdata = 32'hbeef;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_tests++;
      if ({mem_req, mem_we, if_done, dm_done, busy, err} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctl: got %b expected 000000", {mem_req, mem_we, if_done, dm_done, busy, err});
      end
      n_tests++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_data: got %h %h %h %h expected all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
    end
    do_reset;
  endtask

  task automatic test_single_fetch;
    do_reset;
    if_req = 1; if_addr = 32'h40;
    tick;  // cycle 1
    n_tests++;
    if ({mem_req, mem_we, if_done} !== 3'b100 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL fetch_c1: got req/we/done=%b addr=%h expected 100 addr=40", {mem_req, mem_we, if_done}, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h8C020004;
    tick;  // cycle 2
    mem_ready = 0; mem_rdata = 32'h0;
    n_tests++;
    if ({if_done, dm_done, mem_req} !== 3'b100 || if_rdata !== 32'h8C020004) begin
      n_fail++;
      $display("FAIL fetch_c2: got done/dm/req=%b rdata=%h expected 100 8c020004", {if_done, dm_done, mem_req}, if_rdata);
    end
    if_req = 0;
    tick;  // cycle 3
    n_tests++;
    if (if_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c3: got done=%b busy=%b expected 0 0", if_done, busy);
    end
    last_data = 0;
  endtask

  task automatic test_data_write;
    do_reset;
    dm_req = 1; dm_we = 1; dm_addr = 32'h54; dm_wdata = 32'd7;
    for (int c = 1; c <= 4; c++) begin
      tick;
      n_tests++;
      if ({mem_req, mem_we, dm_done, if_done} !== 4'b1100 || mem_addr !== 32'h54 || mem_wdata !== 32'd7) begin
        n_fail++;
        $display("FAIL write_hold c%0d: got req/we/dd/id=%b addr=%h wd=%h expected 1100 54 7",
                 c, {mem_req, mem_we, dm_done, if_done}, mem_addr, mem_wdata);
      end
      mem_ready = (c == 4);
    end
    tick;  // cycle 5
    mem_ready = 0;
    n_tests++;
    if ({dm_done, if_done, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL write_done: got dd/id/req=%b expected 100", {dm_done, if_done, mem_req});
    end
    dm_req = 0; dm_we = 0;
    tick;
    last_data = 1;
  endtask

  task automatic test_tie;
    do_reset;
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    for (int c = 1; c <= 12; c++) begin
      tick;
      mem_ready = (c % 3 == 1);
      n_tests++;
      if (dm_done !== (c == 2 || c == 8) || if_done !== (c == 5 || c == 11)) begin
        n_fail++;
        $display("FAIL tie_done c%0d: got dd=%b id=%b", c, dm_done, if_done);
      end
      if (c % 3 == 1) begin
        n_tests++;
        if (mem_addr !== ((c % 6 == 1) ? 32'h200 : 32'h100)) begin
          n_fail++;
          $display("FAIL tie_grant c%0d: got addr=%h expected %h", c, mem_addr, (c % 6 == 1) ? 32'h200 : 32'h100);
        end
      end
      if (c == 11) begin if_req = 0; dm_req = 0; end
    end
    mem_ready = 0;
    last_data = 0;
  endtask

  task automatic test_timeout;
    do_reset;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    for (int c = 1; c <= 20; c++) begin
      tick;
      mem_rdata = 32'hA5A5_0000 | c;
      n_tests++;
      if (dm_done !== (c == TO + 1) || err !== (c >= TO + 1)) begin
        n_fail++;
        $display("FAIL timeout c%0d: got done=%b err=%b", c, dm_done, err);
      end
      if (c == TO + 1) begin
        n_tests++;
        if (dm_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL timeout_data: got %h expected 0", dm_rdata);
        end
        dm_req = 0;
      end
    end
  endtask

  task automatic test_reset_mid;
    if_req = 1; if_addr = 32'h44;
    tick; tick;  // cycles 1, 2
    reset = 0;
    tick;        // cycle 3
    n_tests++;
    if ({mem_req, if_done, err, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got req/done/err/busy=%b expected 0000", {mem_req, if_done, err, busy});
    end
    reset = 1; last_data = 0; err_m = 0; wdata_m = '0;
    if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    tick;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL reset_tie: got req=%b addr=%h expected 1 20", mem_req, mem_addr);
    end
    mem_ready = 1;
    tick;
    mem_ready = 0; if_req = 0; dm_req = 0;
    n_tests++;
    if ({dm_done, if_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_tie_done: got dd/id=%b expected 10", {dm_done, if_done});
    end
    tick;
  endtask

  task automatic test_coincidence;
    do_reset;
    if_req = 1; if_addr = 32'h3C;
    for (int c = 1; c <= TO + 1; c++) begin
      tick;
      mem_ready = (c == TO);
      mem_rdata = 32'h0BAD_F00D;
      n_tests++;
      if (if_done !== (c == TO + 1) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL coincide c%0d: got done=%b err=%b", c, if_done, err);
      end
    end
    n_tests++;
    if (if_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL coincide_data: got %h expected 0badf00d", if_rdata);
    end
    if_req = 0;
    tick;
  endtask

  task automatic test_random;
    do_reset;
    for (int t = 0; t < 80; t++) begin
      int            sel, w, exp_done;
      bit            win_data, tmo;
      logic [AW-1:0] fa, da, exp_addr;
      logic [DW-1:0] rd, exp_rdata;
      logic          dwe, exp_we;
      sel = $urandom_range(1, 3);
      w   = $urandom_range(0, TO + 2);
      fa  = $urandom; da = $urandom; rd = $urandom | 32'h1; dwe = 1'($urandom);
      // Reference: winner by tie alternation, completion from wait count.
      win_data  = (sel == 2) || (sel == 3 && !last_data);
      last_data = win_data;
      tmo       = (w >= TO);
      exp_done  = tmo ? TO + 1 : w + 2;
      exp_rdata = tmo ? '0 : rd;
      err_m     = err_m | tmo;
      exp_addr  = win_data ? da : fa;
      exp_we    = win_data ? dwe : 1'b0;
      if (win_data) wdata_m = t;
      if_req = sel[0]; dm_req = sel[1]; if_addr = fa; dm_addr = da; dm_we = dwe; dm_wdata = t;
      mem_ready = 1'($urandom);  // ignored while idle
      for (int c = 1; c <= exp_done + 1; c++) begin
        tick;
        mem_ready = (c == w + 1) || (c >= exp_done && 1'($urandom));
        mem_rdata = (c == w + 1) ? rd : $urandom;
        n_tests++;
        if (c < exp_done) begin
          if ({mem_req, busy, if_done, dm_done} !== 4'b1100 || mem_addr !== exp_addr ||
              mem_we !== exp_we || mem_wdata !== wdata_m) begin
            n_fail++;
            $display("FAIL rnd_acc t%0d c%0d: got rb/dn=%b addr=%h we=%b wd=%h expected 1100 %h %b %h",
                     t, c, {mem_req, busy, if_done, dm_done}, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, wdata_m);
          end
        end else if (c == exp_done) begin
          if ({if_done, dm_done} !== {!win_data, win_data} || mem_req !== 1'b0 || err !== err_m ||
              (win_data ? dm_rdata : if_rdata) !== exp_rdata) begin
            n_fail++;
            $display("FAIL rnd_done t%0d: got id/dd=%b req=%b err=%b rdata=%h expected %b 0 %b %h",
                     t, {if_done, dm_done}, mem_req, err, win_data ? dm_rdata : if_rdata,
                     {!win_data, win_data}, err_m, exp_rdata);
          end
          if_req = 0; dm_req = 0;
        end else begin
          if ({busy, if_done, dm_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rnd_idle t%0d: got busy/id/dd=%b expected 000", t, {busy, if_done, dm_done});
          end
        end
      end
    end
    mem_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset;
    test_single_fetch;
    test_data_write;
    test_tie;
    test_timeout;
    test_reset_mid;
    test_coincidence;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Unified-memory arbiter for the pipelined MIPS core. It shares one single-ported instruction/data memory between the fetch stage and the memory stage. Each accepted request is sequenced through a wait-state handshake with the memory, and the result is returned with a one-cycle done pulse. Both pipeline stages hold their request until done, which lets the hazard unit derive stalls from `req & ~done`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum wait cycles per access before abort (≥2)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low; reset is applied on a rising edge of `clk` while `reset`=0
- `if_req`  in  1  fetch read request; held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word; registered; valid while `if_done`=1
- `if_done`  out  1  one-cycle fetch completion pulse
- `dm_req`  in  1  data request; held until `dm_done`
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  write data
- `dm_rdata`  out  DATA_W  read data; registered; valid while `dm_done`=1
- `dm_done`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  access in progress
- `mem_we`  out  1  write strobe; held for the whole access
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched write data
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready`=1
- `mem_ready`  in  1  one-cycle pulse that completes the current access
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  sticky timeout flag

## Operation
- **States:** IDLE, ACC_D, ACC_F, DONE.
- **Arbitration in IDLE:**
  - If only one request is high, that request is granted.
  - If both are high, grant goes to the requester not granted last, tracked in register `last_grant`.
  - `last_grant` resets to fetch, so data wins the first tie.
- **Request latch:** on grant, `mem_addr`, `mem_we` and `mem_wdata` are latched from the winning requester. For a fetch, `mem_we`=0 and `mem_wdata` is unchanged.
- **Transitions:**
  - Grant moves the FSM to ACC_D or ACC_F, clears the wait counter and updates `last_grant`.
  - In ACC_*, `mem_req`=1 with stable address, write strobe and write data.
  - When `mem_ready`=1 in ACC_*, the FSM goes to DONE. The winner's rdata register loads `mem_rdata`; for writes it loads `mem_rdata` as-is, and the requester ignores it.
- **Timeout:**
  - The wait counter increments on each ACC_* cycle without `mem_ready`.
  - If the counter equals TIMEOUT-1 and `mem_ready`=0, the FSM goes to DONE, the winner's rdata loads 0, and `err` is set.
  - `err` stays set until reset.
- **DONE:** the winner's done output is 1 for exactly one cycle and `mem_req`=0. The next state is always IDLE; requests are not sampled in DONE.
- `mem_ready` is ignored in IDLE and DONE.
- The done pulse is never asserted for a requester whose `req` was low at grant. Dropping `req` mid-access is illegal and does not abort the access.
- Counter width is $clog2(TIMEOUT); comparisons are unsigned.

## Timing
- **Reset values:** state = IDLE; `mem_req`, `mem_we`, `if_done`, `dm_done`, `busy` and `err` = 0; `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` = 0; `last_grant` = fetch.
- **Latency:**
  - Request high in IDLE at cycle 0 gives `mem_req`=1 from cycle 1.
  - With `mem_ready` in cycle 1+W, done is high in cycle 2+W. Zero wait states give done in cycle 2.
  - Timeout gives done in cycle TIMEOUT+1.
- **Throughput:** one IDLE cycle between accesses. A requester that re-requests in the cycle after done is sampled in that IDLE cycle.
- **Simultaneous `mem_ready` and timeout threshold in the same cycle:** ready wins, the data is loaded and `err` is unchanged.
- **Reset mid-access:** the access is abandoned, `mem_req` drops on the reset edge, and no done pulse is issued.
- Outputs are all registered except `busy`, which is decoded from state.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x40, memory returns 0x8C020004 with W=0 -> `mem_addr`=0x40 and `mem_we`=0 in cycle 1; `if_done`=1 and `if_rdata`=0x8C020004 in cycle 2 only.
- **Data write:** `dm_req`=1, `dm_we`=1, `dm_addr`=0x54, `dm_wdata`=7, W=3 -> `mem_we`=1, `mem_addr`=0x54 and `mem_wdata`=7 held cycles 1–4; `dm_done` in cycle 5; `if_done` stays 0.
- **Tie alternation:** both requests held continuously after reset, W=0 -> grant order data, fetch, data, fetch; done pulses in cycles 2, 5, 8, 11.
- **Timeout:** `dm_req` read with `mem_ready` never asserted, TIMEOUT=16 -> `dm_done`=1 and `dm_rdata`=0 in cycle 17; `err`=1 from cycle 17 until reset.
- **Reset mid-access:** `reset`=0 in cycle 2 of a W=5 fetch -> the following cycle shows `mem_req`=0, `if_done`=0, `err`=0 and `busy`=0; a subsequent tie grants data first.
- **Ready/timeout coincidence:** `mem_ready` arrives exactly on wait cycle TIMEOUT-1 -> data loaded, `err`=0.
